multdiv: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage, beside the single-cycle `alu`. It takes the same operand buses and produces a result that the execute/memory latch muxes onto the `alu` result path when `data_resultRDY` pulses. Multiply is radix-2 Booth. Divide is non-restoring on magnitudes with a final sign fix. The pipeline stalls on busy.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_if.sv | 28 ++
 rtl/multdiv_addsub.sv | 17 +
 rtl/multdiv.sv | 171 +++++++++++++++++
 tb/tb_multdiv.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multiply/divide unit
//
// Purpose: FSM state encoding, iteration count, counter width and the
//          most-negative 32-bit integer used for the divide overflow case.
// Ports:   none (package).
package multdiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

   localparam int ITERS = 32;
   localparam int CNT_W = 6;
   localparam logic [31:0] INT_MIN = 32'h80000000;

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - operand/result bus between execute stage and multdiv
//
// Purpose: groups the operand, start and result signals of the unit.
// Ports:   data_operandA/B, ctrl_MULT, ctrl_DIV (master -> slave);
//          data_result, data_exception, data_resultRDY (slave -> master).
interface multdiv_if #(
   parameter int WIDTH = 32
);

   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY
   );

endinterface

// File: rtl/multdiv_addsub.sv
// rtl/multdiv_addsub.sv - shared add/subtract for Booth, divide and sign fix
//
// Purpose: sum = a + b when sub = 0, a - b when sub = 1.
// Ports:   a, b (W-bit operands), sub (select), sum (W-bit result).
module multdiv_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   // Two's complement subtract: invert b and inject the carry-in.
   assign sum = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative signed multiply (Booth) / divide (non-restoring)
//
// Purpose: 32-step radix-2 Booth multiply and 32-step non-restoring divide on
//          magnitudes with a final sign fix. A start in any state restarts.
// Ports:   clock, reset (async, active-high);
//          bus (multdiv_if.slave): operands, ctrl_MULT/ctrl_DIV start pulses,
//          registered data_result/data_exception, data_resultRDY pulse.
module multdiv
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic      clock,
   input  logic      reset,
   multdiv_if.slave  bus
);

   localparam int AW = WIDTH + 1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [AW-1:0]    acc;        // Booth accumulator / partial remainder
   logic [AW-1:0]    m;          // multiplicand (sign-extended) or |divisor|
   logic [WIDTH-1:0] q;          // multiplier / quotient
   logic             q_m1;
   logic             neg;
   logic             ovf;
   logic [WIDTH-1:0] result_q;
   logic             exc_q;
   logic             rdy;

   logic             start, is_mul, div_zero, last;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [AW-1:0]    add_a, add_b, sum;
   logic             add_sub;
   logic [AW-1:0]    booth_acc, div_shift;
   logic [WIDTH-1:0] prod_hi, prod_lo;
   logic             mul_ovf;

   assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
   assign is_mul   = bus.ctrl_MULT;
   assign div_zero = ~bus.ctrl_MULT & (bus.data_operandB == '0);
   assign last     = (cnt == CNT_W'(ITERS - 1));

   // INT_MIN maps onto itself, which read as unsigned is exactly 2^31.
   assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
   assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

   // Booth: only 01/10 pairs take the adder result; the shift is applied after.
   assign booth_acc = (q[0] ^ q_m1) ? sum : acc;
   assign prod_hi   = booth_acc[AW-1:1];
   assign prod_lo   = {booth_acc[0], q[WIDTH-1:1]};
   assign mul_ovf   = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});

   // Non-restoring: remainder and quotient shift left together.
   assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};

   multdiv_addsub #(.W(AW)) u_addsub (
      .a   (add_a),
      .b   (add_b),
      .sub (add_sub),
      .sum (sum)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         MUL:     state_nxt = last ? DONE : MUL;
         DIV:     state_nxt = last ? FIX : DIV;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (start) begin
         if (is_mul)        state_nxt = MUL;
         else if (div_zero) state_nxt = DONE;
         else               state_nxt = DIV;
      end
   end

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_sub = 1'b0;
      rdy     = 1'b0;
      case (state)
         MUL: begin
            add_a   = acc;
            add_b   = m;
            add_sub = q[0];
         end
         DIV: begin
            add_a   = div_shift;
            add_b   = m;
            add_sub = ~acc[AW-1];
         end
         FIX: begin
            add_a   = '0;
            add_b   = {1'b0, q};
            add_sub = 1'b1;
         end
         DONE:    rdy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         acc      <= '0;
         m        <= '0;
         q        <= '0;
         q_m1     <= 1'b0;
         neg      <= 1'b0;
         ovf      <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else if (start) begin
         cnt  <= '0;
         acc  <= '0;
         q_m1 <= 1'b0;
         neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         ovf  <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
         if (is_mul) begin
            q <= bus.data_operandB;
            m <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
         end else begin
            q <= abs_a;
            m <= {1'b0, abs_b};
         end
         if (div_zero) begin
            result_q <= '0;
            exc_q    <= 1'b1;
         end
      end else begin
         case (state)
            MUL: begin
               acc  <= {booth_acc[AW-1], booth_acc[AW-1:1]};
               q    <= prod_lo;
               q_m1 <= q[0];
               cnt  <= cnt + 1'b1;
               if (last) begin
                  result_q <= prod_lo;
                  exc_q    <= mul_ovf;
               end
            end
            DIV: begin
               acc <= sum;
               q   <= {q[WIDTH-2:0], ~sum[AW-1]};
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               result_q <= neg ? sum[WIDTH-1:0] : q;
               exc_q    <= ovf;
            end
            default: ;
         endcase
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy;

endmodule

// File: tb/tb_multdiv.sv
// tb/tb_multdiv.sv - directed self-checking bench for multdiv
module tb_multdiv;

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   multdiv_if #(.WIDTH(32)) bus ();

   multdiv #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Issue one start and watch 45 falling edges; lat is the first negedge
   // index (1 = cycle right after the start edge) at which RDY is seen.
   task automatic run_op(input logic do_mul, input logic do_div,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nrdy,
                         output logic [31:0] res, output logic exc);
      @(negedge clock);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = do_mul;
      bus.ctrl_DIV      = do_div;
      @(posedge clock);
      #1;
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      lat  = 0;
      nrdy = 0;
      res  = 'x;
      exc  = 1'bx;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clock);
         if (bus.data_resultRDY === 1'b1) begin
            nrdy++;
            if (lat == 0) begin
               lat = n;
               res = bus.data_result;
               exc = bus.data_exception;
            end
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.data_result, bus.data_exception, bus.data_resultRDY} !== 34'h0) begin
         failures++;
         $display("FAIL reset outputs got=%h/%b/%b exp=0/0/0",
                  bus.data_result, bus.data_exception, bus.data_resultRDY);
      end
   endtask

   task automatic test_mult();
      logic [31:0] va[7] = '{32'd7, 32'h00010000, 32'h7FFFFFFF, 32'h80000000,
                             32'hFFFFFFFF, 32'h80000000, 32'd6};
      logic [31:0] vb[7] = '{32'hFFFFFFFD, 32'h00010000, 32'd1, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'd1, 32'd7};
      logic [31:0] er[7] = '{32'hFFFFFFEB, 32'h0, 32'h7FFFFFFF, 32'h80000000,
                             32'h1, 32'h80000000, 32'd42};
      logic        ee[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int lat, nrdy;
      logic [31:0] res;
      logic exc;
      for (int i = 0; i < 7; i++) begin
         // last vector raises both starts: must be treated as multiply
         run_op(1'b1, (i == 6), va[i], vb[i], lat, nrdy, res, exc);
         checks++;
         if (res !== er[i]) begin
            failures++;
            $display("FAIL mult[%0d] result got=%h exp=%h", i, res, er[i]);
         end
         checks++;
         if (exc !== ee[i]) begin
            failures++;
            $display("FAIL mult[%0d] exception got=%b exp=%b", i, exc, ee[i]);
         end
         checks++;
         if (lat != 33 || nrdy != 1) begin
            failures++;
            $display("FAIL mult[%0d] rdy lat=%0d count=%0d exp lat=33 count=1", i, lat, nrdy);
         end
      end
   endtask

   task automatic test_div();
      logic [31:0] va[7] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd7,
                             32'h80000000, 32'h80000000, 32'd5};
      logic [31:0] vb[7] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100,
                             32'hFFFFFFFF, 32'd1, 32'd0};
      logic [31:0] er[7] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0000000E, 32'h0,
                             32'h80000000, 32'h80000000, 32'h0};
      logic        ee[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int          el[7] = '{34, 34, 34, 34, 34, 34, 1};
      int lat, nrdy;
      logic [31:0] res;
      logic exc;
      for (int i = 0; i < 7; i++) begin
         run_op(1'b0, 1'b1, va[i], vb[i], lat, nrdy, res, exc);
         checks++;
         if (res !== er[i]) begin
            failures++;
            $display("FAIL div[%0d] result got=%h exp=%h", i, res, er[i]);
         end
         checks++;
         if (exc !== ee[i]) begin
            failures++;
            $display("FAIL div[%0d] exception got=%b exp=%b", i, exc, ee[i]);
         end
         checks++;
         if (lat != el[i] || nrdy != 1) begin
            failures++;
            $display("FAIL div[%0d] rdy lat=%0d count=%0d exp lat=%0d count=1",
                     i, lat, nrdy, el[i]);
         end
      end
   endtask

   task automatic test_abort();
      int nrdy = 0;
      int lat = 0;
      logic [31:0] res = 'x;
      logic exc = 1'bx;
      @(negedge clock);
      bus.data_operandA = 32'd3;
      bus.data_operandB = 32'd4;
      bus.ctrl_MULT     = 1'b1;
      @(posedge clock);
      #1;
      bus.ctrl_MULT = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clock);
         if (bus.data_resultRDY === 1'b1) begin
            nrdy++;
            if (lat == 0) begin
               lat = n;
               res = bus.data_result;
               exc = bus.data_exception;
            end
         end
         if (n == 10) begin
            bus.data_operandA = 32'd20;
            bus.data_operandB = 32'd5;
            bus.ctrl_DIV      = 1'b1;
         end
         if (n == 11) bus.ctrl_DIV = 1'b0;
      end
      checks++;
      if (nrdy != 1 || lat != 44) begin
         failures++;
         $display("FAIL abort rdy count=%0d lat=%0d exp count=1 lat=44", nrdy, lat);
      end
      checks++;
      if (res !== 32'd4 || exc !== 1'b0) begin
         failures++;
         $display("FAIL abort result got=%h/%b exp=00000004/0", res, exc);
      end
   endtask

   task automatic test_start_in_done();
      int nrdy = 0;
      int lat2 = 0;
      logic [31:0] res1 = 'x;
      logic [31:0] res2 = 'x;
      @(negedge clock);
      bus.data_operandA = 32'd2;
      bus.data_operandB = 32'd3;
      bus.ctrl_MULT     = 1'b1;
      @(posedge clock);
      #1;
      bus.ctrl_MULT = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clock);
         if (bus.data_resultRDY === 1'b1) begin
            nrdy++;
            if (nrdy == 1) res1 = bus.data_result;
            if (nrdy == 2) begin
               res2 = bus.data_result;
               lat2 = n;
            end
         end
         if (n == 33) begin
            bus.data_operandA = 32'd5;
            bus.data_operandB = 32'd6;
            bus.ctrl_MULT     = 1'b1;
         end
         if (n == 34) bus.ctrl_MULT = 1'b0;
      end
      checks++;
      if (nrdy != 2 || res1 !== 32'd6) begin
         failures++;
         $display("FAIL done_restart first count=%0d res=%h exp count=2 res=00000006", nrdy, res1);
      end
      checks++;
      if (res2 !== 32'd30 || lat2 != 66) begin
         failures++;
         $display("FAIL done_restart second res=%h lat=%0d exp res=0000001e lat=66", res2, lat2);
      end
   endtask

   task automatic test_reset_mid();
      int nrdy = 0;
      int lat, nr;
      logic [31:0] res;
      logic exc;
      @(negedge clock);
      bus.data_operandA = 32'd20;
      bus.data_operandB = 32'd5;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      bus.ctrl_DIV = 1'b0;
      for (int n = 1; n <= 12; n++) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.data_result, bus.data_exception, bus.data_resultRDY} !== 34'h0) begin
         failures++;
         $display("FAIL reset_mid outputs got=%h/%b/%b exp=0/0/0",
                  bus.data_result, bus.data_exception, bus.data_resultRDY);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (bus.data_resultRDY === 1'b1) nrdy++;
      end
      checks++;
      if (nrdy != 0) begin
         failures++;
         $display("FAIL reset_mid spurious rdy count=%0d exp=0", nrdy);
      end
      run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, lat, nr, res, exc);
      checks++;
      if (res !== 32'hFFFFFFEB || exc !== 1'b0 || lat != 33 || nr != 1) begin
         failures++;
         $display("FAIL reset_mid restart res=%h exc=%b lat=%0d count=%0d exp ffffffeb/0/33/1",
                  res, exc, lat, nr);
      end
   endtask

   initial begin
      reset             = 1'b1;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      reset = 1'b0;
      test_mult();
      test_div();
      test_abort();
      test_start_in_done();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
